// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline stage: two-entry elastic buffer (main + skid) with valid/ready on both sides,
// synchronous flush, and write enables forced low on bubbles.
module ex_mem_skid #(
   parameter int DATA_WIDTH   = 32,
   parameter int REG_WIDTH    = 5,
   parameter int PC_TGT_WIDTH = DATA_WIDTH - 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_flush,
   input  logic                    i_valid_EX,
   output logic                    o_ready_EX,
   input  logic [DATA_WIDTH-1:0]   i_alu_result_EX,
   input  logic [DATA_WIDTH-1:0]   i_write_data_EX,
   input  logic [DATA_WIDTH-1:0]   i_pc_plus4_EX,
   input  logic [REG_WIDTH-1:0]    i_rd_EX,
   input  logic                    i_reg_write_EX,
   input  logic [1:0]              i_result_src_EX,
   input  logic                    i_mem_write_EX,
   input  logic [PC_TGT_WIDTH-1:0] i_pc_target_EX,
   output logic                    o_valid_M,
   input  logic                    i_ready_M,
   output logic [DATA_WIDTH-1:0]   o_alu_result_M,
   output logic [DATA_WIDTH-1:0]   o_write_data_M,
   output logic [DATA_WIDTH-1:0]   o_pc_plus4_M,
   output logic [REG_WIDTH-1:0]    o_rd_M,
   output logic                    o_reg_write_M,
   output logic [1:0]              o_result_src_M,
   output logic                    o_mem_write_M,
   output logic [PC_TGT_WIDTH-1:0] o_pc_target_M,
   output logic [1:0]              o_occupancy
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0]   alu_result;
      logic [DATA_WIDTH-1:0]   write_data;
      logic [DATA_WIDTH-1:0]   pc_plus4;
      logic [REG_WIDTH-1:0]    rd;
      logic                    reg_write;
      logic [1:0]              result_src;
      logic                    mem_write;
      logic [PC_TGT_WIDTH-1:0] pc_target;
   } payload_t;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t   state_reg;
   payload_t main_reg;
   payload_t skid_reg;
   payload_t in_pl;
   logic     valid_m_reg;
   logic     ready_ex_reg;
   logic     acc_in;
   logic     acc_out;

   assign in_pl = '{alu_result: i_alu_result_EX, write_data: i_write_data_EX,
                    pc_plus4: i_pc_plus4_EX, rd: i_rd_EX, reg_write: i_reg_write_EX,
                    result_src: i_result_src_EX, mem_write: i_mem_write_EX,
                    pc_target: i_pc_target_EX};

   // Ready comes from a flop only, so MEM back-pressure never reaches EX combinationally.
   assign acc_in  = i_valid_EX & ready_ex_reg;
   assign acc_out = valid_m_reg & i_ready_M;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= EMPTY;
         main_reg     <= '0;
         skid_reg     <= '0;
         valid_m_reg  <= 1'b0;
         ready_ex_reg <= 1'b1;
      end else if (i_flush) begin
         state_reg    <= EMPTY;
         valid_m_reg  <= 1'b0;
         ready_ex_reg <= 1'b1;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (acc_in) begin
                  main_reg    <= in_pl;
                  valid_m_reg <= 1'b1;
                  state_reg   <= ONE;
               end
            end
            ONE: begin
               if (acc_in && acc_out) begin
                  main_reg <= in_pl;
               end else if (acc_in) begin
                  skid_reg     <= in_pl;
                  ready_ex_reg <= 1'b0;
                  state_reg    <= TWO;
               end else if (acc_out) begin
                  valid_m_reg <= 1'b0;
                  state_reg   <= EMPTY;
               end
            end
            TWO: begin
               if (acc_out) begin
                  main_reg     <= skid_reg;
                  ready_ex_reg <= 1'b1;
                  state_reg    <= ONE;
               end
            end
            default: begin
               state_reg    <= EMPTY;
               valid_m_reg  <= 1'b0;
               ready_ex_reg <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready_EX     = ready_ex_reg;
   assign o_valid_M      = valid_m_reg;
   assign o_occupancy    = state_reg;
   assign o_alu_result_M = main_reg.alu_result;
   assign o_write_data_M = main_reg.write_data;
   assign o_pc_plus4_M   = main_reg.pc_plus4;
   assign o_rd_M         = main_reg.rd;
   assign o_result_src_M = main_reg.result_src;
   assign o_pc_target_M  = main_reg.pc_target;
   assign o_reg_write_M  = main_reg.reg_write & valid_m_reg;
   assign o_mem_write_M  = main_reg.mem_write & valid_m_reg;

endmodule
